// File: rtl/dct2d_pkg.sv
// Shared types for the 2-D DCT scheduler: block size, FSM states, transfer-counter index.
package dct2d_pkg;
  localparam int N = 8;

  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

  // Counts 0..8 so "all eight done" is representable.
  typedef logic [3:0] idx_t;
endpackage

// File: rtl/dct2d_tbuf.sv
// 8x8 transpose buffer: whole-row write port, combinational whole-column read port.
module dct2d_tbuf
  import dct2d_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                we,
  input  logic [2:0]          wr_row,
  input  logic [0:N-1][W-1:0] wr_data,
  input  logic [2:0]          rd_col,
  output logic [0:N-1][W-1:0] rd_data
);

  logic [0:N-1][0:N-1][W-1:0] mem;

  // Data-only storage: contents are always fully rewritten before any read.
  for (genvar r = 0; r < N; r++) begin : g_row
    always_ff @(posedge clk_i) begin
      if (we && wr_row == 3'(r)) mem[r] <= wr_data;
    end
    assign rd_data[r] = mem[r][rd_col];
  end

endmodule

// File: rtl/dct2d_sched.sv
// Row/column scheduler sharing one external Dct1D for an 8x8 2-D DCT.
// Optional perf counters under `DCT2D_SCHED_PERF_EN.
module dct2d_sched
  import dct2d_pkg::*;
#(
  parameter int DinWidth  = 8,
  parameter int DoutWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic [0:N-1][DinWidth-1:0]         s_data_i,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic signed [0:N-1][DoutWidth-1:0] m_data_o,
  output logic                               m_last_o,
  output logic                               dct_s_valid_o,
  input  logic                               dct_s_ready_i,
  output logic [0:N-1][DoutWidth-1:0]        dct_s_data_o,
  input  logic                               dct_m_valid_i,
  output logic                               dct_m_ready_o,
  input  logic signed [0:N-1][DoutWidth-1:0] dct_m_data_i,
`ifdef DCT2D_SCHED_PERF_EN
  output logic [31:0]                        perf_blocks_o,
  output logic [31:0]                        perf_stall_o,
`endif
  output logic                               busy_o
);

  state_t state, state_n;
  idx_t   fc, fc_n, rc, rc_n;
  logic   tb_we;
  logic   feed_x, ret_x;
  logic [0:N-1][DoutWidth-1:0] s_zext, col_data;

  for (genvar i = 0; i < N; i++) begin : g_zext
    assign s_zext[i] = DoutWidth'(s_data_i[i]);
  end

  dct2d_tbuf #(.W(DoutWidth)) u_tbuf (
    .clk_i   (clk_i),
    .we      (tb_we),
    .wr_row  (rc[2:0]),
    .wr_data (dct_m_data_i),
    .rd_col  (fc[2:0]),
    .rd_data (col_data)
  );

  assign feed_x = dct_s_valid_o & dct_s_ready_i;
  assign ret_x  = dct_m_valid_i & dct_m_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      fc    <= '0;
      rc    <= '0;
    end else begin
      state <= state_n;
      fc    <= fc_n;
      rc    <= rc_n;
    end
  end

  always_comb begin
    state_n       = state;
    fc_n          = fc;
    rc_n          = rc;
    tb_we         = 1'b0;
    s_ready_o     = 1'b0;
    m_valid_o     = 1'b0;
    m_data_o      = '0;
    m_last_o      = 1'b0;
    dct_s_valid_o = 1'b0;
    dct_s_data_o  = '0;
    dct_m_ready_o = 1'b0;
    case (state)
      IDLE: begin
        // The first row is handed straight to Dct1D, so only accept it when Dct1D can take it.
        s_ready_o     = dct_s_ready_i;
        dct_s_valid_o = s_valid_i;
        dct_s_data_o  = s_zext;
        if (s_valid_i && dct_s_ready_i) begin
          state_n = ROW;
          fc_n    = 4'd1;
          rc_n    = '0;
        end
      end
      ROW: begin
        s_ready_o     = dct_s_ready_i & (fc < 4'(N));
        dct_s_valid_o = s_valid_i & (fc < 4'(N));
        dct_s_data_o  = s_zext;
        dct_m_ready_o = 1'b1;
        if (feed_x) fc_n = fc + 4'd1;
        if (ret_x) begin
          tb_we = 1'b1;
          if (rc == 4'(N - 1)) begin
            state_n = COL;
            fc_n    = '0;
            rc_n    = '0;
          end else begin
            rc_n = rc + 4'd1;
          end
        end
      end
      COL: begin
        dct_s_valid_o = fc < 4'(N);
        dct_s_data_o  = col_data;
        m_valid_o     = dct_m_valid_i;
        m_data_o      = dct_m_data_i;
        dct_m_ready_o = m_ready_i;
        m_last_o      = rc == 4'(N - 1);
        if (feed_x) fc_n = fc + 4'd1;
        if (ret_x) begin
          if (rc == 4'(N - 1)) begin
            state_n = IDLE;
            fc_n    = '0;
            rc_n    = '0;
          end else begin
            rc_n = rc + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Hold every handshake low while reset is applied.
    if (rst_i) begin
      s_ready_o     = 1'b0;
      m_valid_o     = 1'b0;
      m_data_o      = '0;
      m_last_o      = 1'b0;
      dct_s_valid_o = 1'b0;
      dct_m_ready_o = 1'b0;
      tb_we         = 1'b0;
    end
  end

  assign busy_o = state != IDLE;

`ifdef DCT2D_SCHED_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_blocks_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (m_valid_o && m_ready_i && m_last_o) perf_blocks_o <= perf_blocks_o + 32'd1;
      if (state == COL && m_valid_o && !m_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct2d_sched.sv
// Bench for dct2d_sched with an identity Dct1D stub (fixed latency) and a transpose reference.
module tb_dct2d_sched;
  import dct2d_pkg::*;

  localparam int DW = 8;
  localparam int OW = 16;
  typedef logic [0:7][DW-1:0] row_t;
  typedef logic [0:7][OW-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_valid, s_ready, m_valid, m_ready, m_last;
  logic dct_s_valid, dct_s_ready, dct_m_valid, dct_m_ready, busy;
  row_t s_data;
  logic signed [0:7][OW-1:0] m_data, dct_m_data;
  vec_t dct_s_data;
`ifdef DCT2D_SCHED_PERF_EN
  logic [31:0] perf_blocks, perf_stall;
`endif

  dct2d_sched #(.DinWidth(DW), .DoutWidth(OW)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .dct_s_valid_o(dct_s_valid), .dct_s_ready_i(dct_s_ready), .dct_s_data_o(dct_s_data),
    .dct_m_valid_i(dct_m_valid), .dct_m_ready_o(dct_m_ready), .dct_m_data_i(dct_m_data),
`ifdef DCT2D_SCHED_PERF_EN
    .perf_blocks_o(perf_blocks), .perf_stall_o(perf_stall),
`endif
    .busy_o(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // stub Dct1D, row source, column sink
  vec_t sq_d[$];
  int   sq_t[$];
  row_t src[$];
  vec_t got[$];
  bit   got_last[$];
  int   cyc = 0, gap = 0, gap_max = 0, mode = 0, stall_left = 0;
  int   rows_in = 0, outs = 0;

  task automatic tick();
    bit in_x, fd_x, rt_x, out_x, out_l;
    vec_t fd_d, out_d;
    @(negedge clk);
    in_x  = s_valid && s_ready;
    fd_x  = dct_s_valid && dct_s_ready;
    rt_x  = dct_m_valid && dct_m_ready;
    out_x = m_valid && m_ready;
    fd_d  = dct_s_data;
    out_d = m_data;
    out_l = m_last;
    if (!rst && rows_in == 8 && outs < 8) chk("sready_col", s_ready, 0);
    if (m_valid && !m_ready && stall_left > 0) stall_left--;
    @(posedge clk);
    #1;
    cyc++;
    if (rt_x) begin
      void'(sq_d.pop_front());
      void'(sq_t.pop_front());
    end
    if (fd_x) begin
      sq_d.push_back(fd_d);
      sq_t.push_back(cyc + 2);
    end
    dct_m_valid = sq_d.size() > 0 && sq_t[0] <= cyc;
    dct_m_data  = dct_m_valid ? sq_d[0] : '0;
    dct_s_ready = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
    if (in_x) begin
      void'(src.pop_front());
      rows_in++;
      gap = $urandom_range(gap_max, 0);
    end
    if (gap > 0) begin
      s_valid = 1'b0;
      gap--;
    end else if (src.size() > 0) begin
      s_valid = 1'b1;
      s_data  = src[0];
    end else begin
      s_valid = 1'b0;
    end
    if (out_x) begin
      got.push_back(out_d);
      got_last.push_back(out_l);
      outs++;
    end
    case (mode)
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(1, 0));
      3:       m_ready = stall_left == 0;
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic start_block(input bit ramp, output row_t rows[8]);
    for (int r = 0; r < 8; r++)
      for (int e = 0; e < 8; e++)
        rows[r][e] = ramp ? DW'(8 * r + e) : DW'($urandom);
    for (int r = 0; r < 8; r++) src.push_back(rows[r]);
    rows_in = 0;
    outs    = 0;
    got.delete();
    got_last.delete();
  endtask

  task automatic run_block(input string tag, input bit ramp, input int gmax, input int rmode);
    row_t rows[8];
    vec_t exp;
    int   budget;
    gap_max = gmax;
    mode    = rmode;
    start_block(ramp, rows);
    budget = 0;
    while (outs < 8 && budget < 800) begin
      tick();
      budget++;
    end
    if (outs < 8) chk({tag, "_timeout"}, outs, 8);
    // 2-D result of an identity 1-D transform is the transpose of the input block.
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      for (int i = 0; i < 8; i++) exp[i] = OW'(rows[i][k]);
      chk($sformatf("%s_col%0d", tag, k), got[k], exp);
      chk($sformatf("%s_last%0d", tag, k), got_last[k], k == 7);
    end
    mode = 0;
    repeat (6) tick();
    chk({tag, "_count"}, got.size(), 8);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_srdy"}, s_ready, 0);
    chk({tag, "_mval"}, m_valid, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_dsval"}, dct_s_valid, 0);
    chk({tag, "_dmrdy"}, dct_m_ready, 0);
  endtask

  task automatic clear_env();
    sq_d.delete();
    sq_t.delete();
    src.delete();
    s_valid     = 1'b0;
    dct_m_valid = 1'b0;
    dct_m_data  = '0;
    gap         = 0;
  endtask

  initial begin
    row_t rows[8];
    int   budget;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    dct_s_ready = 1'b1; dct_m_valid = 1'b0; dct_m_data = '0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();
    chk("idle_srdy", s_ready, 1);

    run_block("ramp", 1'b1, 0, 0);
    run_block("rand", 1'b0, 0, 0);
    run_block("toggle", 1'b0, 0, 1);
    run_block("gaps", 1'b0, 4, 0);
    run_block("mixed", 1'b0, 4, 2);

    // abandon a block after four rows
    gap_max = 0;
    mode    = 0;
    start_block(1'b0, rows);
    budget = 0;
    while (rows_in < 4 && budget < 100) begin
      tick();
      budget++;
    end
    chk("midrst_rows", rows_in, 4);
    chk("midrst_busy_pre", busy, 1);
    rst = 1'b1;
    clear_env();
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    tick();
    run_block("after_rst", 1'b0, 0, 0);

`ifdef DCT2D_SCHED_PERF_EN
    rst = 1'b1;
    clear_env();
    tick();
    rst = 1'b0;
    tick();
    stall_left = 5;
    for (int b = 0; b < 3; b++) begin
      gap_max = 0;
      mode    = 3;
      start_block(1'b0, rows);
      budget = 0;
      while (outs < 8 && budget < 400) begin
        tick();
        budget++;
      end
      chk($sformatf("perf_outs%0d", b), outs, 8);
      mode = 0;
      repeat (4) tick();
    end
    chk("perf_blocks", perf_blocks, 3);
    chk("perf_stall", perf_stall, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
